// File: rtl/hcsr04_scan_ctrl_if.sv
// Result bus from the HC-SR04 scan controller to display/UART consumers.
interface hcsr04_scan_ctrl_if;
  logic        meas_valid;
  logic [2:0]  meas_ch;
  logic [15:0] meas_us;
  logic        meas_timeout;
  logic [15:0] meas_cm;

  modport master (output meas_valid, meas_ch, meas_us, meas_timeout, meas_cm);
  modport slave  (input  meas_valid, meas_ch, meas_us, meas_timeout, meas_cm);
endinterface

// File: rtl/hcsr04_scan_ctrl.sv
// Round-robin HC-SR04 scheduler: one trigger/echo measurement per fixed slot, one result strobe per slot.
// Optional cm conversion is built when HCSR04_CM_CONV_EN is defined; otherwise meas_cm is tied to 0.
module hcsr04_scan_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int TRIG_US    = 15,
  parameter int TIMEOUT_US = 30000,
  parameter int SLOT_US    = 60000
) (
  input  logic                clk_us,
  input  logic                rstn,
  input  logic                en_i,
  input  logic [NUM_CH-1:0]   echo_i,
  output logic [NUM_CH-1:0]   trig_o,
  output logic                busy_o,
  output logic [2:0]          cur_ch_o,
  hcsr04_scan_ctrl_if.master  meas
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TRIG    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_HOLDOFF = 3'd4;

  localparam logic [16:0] TRIG_END = 17'(TRIG_US - 1);
  localparam logic [16:0] WAIT_END = 17'(TRIG_US + TIMEOUT_US - 1);
  localparam logic [16:0] SLOT_END = 17'(SLOT_US - 1);
  localparam logic [15:0] TMO      = 16'(TIMEOUT_US);
  localparam logic [15:0] TMO_M1   = 16'(TIMEOUT_US - 1);
  localparam logic [2:0]  LAST_CH  = 3'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

  logic [2:0]        state_q, state_d;
  logic [16:0]       slot_q, slot_d;
  logic [2:0]        ch_q, ch_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic              vld_q, vld_d;
  logic [2:0]        mch_q, mch_d;
  logic [15:0]       mus_q, mus_d;
  logic              mto_q, mto_d;
  logic [NUM_CH-1:0] echo_m_q, echo_s_q, echo_p_q;
  logic [NUM_CH-1:0] sel_mask;
  logic              echo_sel, echo_rise;

  assign sel_mask  = ONE << ch_q;
  assign echo_sel  = |(echo_s_q & sel_mask);
  assign echo_rise = |(echo_s_q & ~echo_p_q & sel_mask);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    ch_d    = ch_q;
    wcnt_d  = wcnt_q;
    vld_d   = 1'b0;
    mch_d   = mch_q;
    mus_d   = mus_q;
    mto_d   = mto_q;
    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          state_d = S_TRIG;
          slot_d  = '0;
        end
      end
      S_TRIG: begin
        slot_d = slot_q + 17'd1;
        if (slot_q == TRIG_END) state_d = S_WAIT;
      end
      S_WAIT: begin
        slot_d = slot_q + 17'd1;
        if (echo_rise) begin
          wcnt_d  = 16'd1;
          state_d = S_MEASURE;
        end else if (slot_q == WAIT_END) begin
          vld_d   = 1'b1;
          mch_d   = ch_q;
          mus_d   = TMO;
          mto_d   = 1'b1;
          state_d = S_HOLDOFF;
        end
      end
      S_MEASURE: begin
        slot_d = slot_q + 17'd1;
        if (!echo_sel) begin
          vld_d   = 1'b1;
          mch_d   = ch_q;
          mus_d   = wcnt_q;
          mto_d   = 1'b0;
          state_d = S_HOLDOFF;
        end else if (wcnt_q == TMO_M1) begin
          vld_d   = 1'b1;
          mch_d   = ch_q;
          mus_d   = TMO;
          mto_d   = 1'b1;
          state_d = S_HOLDOFF;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      S_HOLDOFF: begin
        // >= rather than ==: a late rise plus a full-length echo can run past the nominal slot end.
        if (slot_q >= SLOT_END) begin
          slot_d  = '0;
          ch_d    = (ch_q == LAST_CH) ? 3'd0 : ch_q + 3'd1;
          state_d = en_i ? S_TRIG : S_IDLE;
        end else begin
          slot_d = slot_q + 17'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_us or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      slot_q   <= '0;
      ch_q     <= '0;
      wcnt_q   <= '0;
      vld_q    <= 1'b0;
      mch_q    <= '0;
      mus_q    <= '0;
      mto_q    <= 1'b0;
      echo_m_q <= '0;
      echo_s_q <= '0;
      echo_p_q <= '0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      ch_q     <= ch_d;
      wcnt_q   <= wcnt_d;
      vld_q    <= vld_d;
      mch_q    <= mch_d;
      mus_q    <= mus_d;
      mto_q    <= mto_d;
      echo_m_q <= echo_i;
      echo_s_q <= echo_m_q;
      echo_p_q <= echo_s_q;
    end
  end

  // Decoded from state so an async reset drops the trigger without waiting for a clock.
  assign trig_o   = (state_q == S_TRIG) ? sel_mask : '0;
  assign busy_o   = (state_q != S_IDLE);
  assign cur_ch_o = ch_q;

  assign meas.meas_valid   = vld_q;
  assign meas.meas_ch      = mch_q;
  assign meas.meas_us      = mus_q;
  assign meas.meas_timeout = mto_q;

`ifdef HCSR04_CM_CONV_EN
  logic [15:0] cm_q, cm_d;
  logic [26:0] cm_prod;

  // 1130/65536 approximates 1/58 us-per-cm.
  assign cm_prod = 27'(mus_d) * 27'd1130;
  assign cm_d    = mto_d ? 16'd0 : 16'(cm_prod >> 16);

  always_ff @(posedge clk_us or negedge rstn) begin
    if (!rstn) begin
      cm_q <= '0;
    end else if (vld_d) begin
      cm_q <= cm_d;
    end
  end

  assign meas.meas_cm = cm_q;
`else
  assign meas.meas_cm = 16'd0;
`endif

endmodule
